// File: rtl/key_event_pkg.sv
// Shared definitions for key_event: FSM state encodings and default timing constants
// (the defaults are also consumed by the board top for debounce/long-press tuning).
package key_event_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESSED = 2'd1,
    ST_LONG    = 2'd2
  } state_e;

  localparam int unsigned KE_LONG_CYCLES   = 50_000_000;
  localparam int unsigned KE_REPEAT_CYCLES = 10_000_000;
  localparam int unsigned KE_CNT_W         = 32;

endpackage

// File: rtl/key_event.sv
// Converts the debounced key level into press/release/long-press/repeat pulses plus a held level.
// Auto-repeat is built only when KEY_EVENT_REPEAT_EN is defined; otherwise repeat_o is constant 0.
module key_event
  import key_event_pkg::*;
#(
  parameter int unsigned LONG_CYCLES   = KE_LONG_CYCLES,
  parameter int unsigned REPEAT_CYCLES = KE_REPEAT_CYCLES,
  parameter int unsigned CNT_W         = KE_CNT_W
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic in_i,
  output logic press_o,
  output logic release_o,
  output logic long_press_o,
  output logic repeat_o,
  output logic held_o
);

  if (LONG_CYCLES < 2 || REPEAT_CYCLES < 2) begin : g_bad_params
    $error("key_event: LONG_CYCLES and REPEAT_CYCLES must both be >= 2");
  end

  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
`ifdef KEY_EVENT_REPEAT_EN
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);
`endif

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             press_q;
  logic             release_q;
  logic             long_q;
  logic             repeat_q;
  logic             held_q;

  // held_q tracks the next state, so it moves on the same edge as press/release.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
      repeat_q  <= 1'b0;
      held_q    <= 1'b0;
    end else begin
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
      repeat_q  <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (in_i) begin
            state_q <= ST_PRESSED;
            press_q <= 1'b1;
            held_q  <= 1'b1;
            cnt_q   <= '0;
          end
        end
        ST_PRESSED: begin
          if (!in_i) begin
            state_q   <= ST_IDLE;
            release_q <= 1'b1;
            held_q    <= 1'b0;
            cnt_q     <= '0;
          end else if (cnt_q == LONG_LAST) begin
            state_q <= ST_LONG;
            long_q  <= 1'b1;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_LONG: begin
          if (!in_i) begin
            state_q   <= ST_IDLE;
            release_q <= 1'b1;
            held_q    <= 1'b0;
            cnt_q     <= '0;
          end else begin
`ifdef KEY_EVENT_REPEAT_EN
            if (cnt_q == REP_LAST) begin
              repeat_q <= 1'b1;
              cnt_q    <= '0;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
`else
            cnt_q <= '0;
`endif
          end
        end
        default: begin
          state_q <= ST_IDLE;
          held_q  <= 1'b0;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign press_o      = press_q;
  assign release_o    = release_q;
  assign long_press_o = long_q;
  assign repeat_o     = repeat_q;
  assign held_o       = held_q;

endmodule

// File: tb/tb_key_event.sv
// Scoreboard bench for key_event with LONG_CYCLES=8, REPEAT_CYCLES=4; repeat expectations
// follow KEY_EVENT_REPEAT_EN.
module tb_key_event;
  localparam int unsigned LONG = 8;
  localparam int unsigned REP  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_k = 1'b0;
  logic press, rel, lng, rpt, held;

  key_event #(
    .LONG_CYCLES  (LONG),
    .REPEAT_CYCLES(REP),
    .CNT_W        (8)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .in_i        (in_k),
    .press_o     (press),
    .release_o   (rel),
    .long_press_o(lng),
    .repeat_o    (rpt),
    .held_o      (held)
  );

  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  logic [1:0] stim_q[$];
  logic [4:0] exp_q[$];

  // Expected {press,release,long,repeat,held} k edges after the first sampled-high edge
  // of a press lasting len sampled-high edges.
  function automatic logic [4:0] exp_at(int k, int len);
    logic p = 1'b0, r = 1'b0, l = 1'b0, rp = 1'b0, h = 1'b0;
    if (k == 0) begin
      p = 1'b1; h = 1'b1;
    end else if (k < len) begin
      h = 1'b1;
      if (k == int'(LONG)) l = 1'b1;
`ifdef KEY_EVENT_REPEAT_EN
      if (k > int'(LONG) && ((k - int'(LONG)) % int'(REP)) == 0) rp = 1'b1;
`endif
    end else if (k == len) begin
      r = 1'b1;
    end
    return {p, r, l, rp, h};
  endfunction

  task automatic push_cycle(input logic r, input logic i, input logic [4:0] e);
    stim_q.push_back({r, i});
    exp_q.push_back(e);
  endtask

  task automatic push_press(input int len, input int idle);
    for (int k = 0; k < len + idle; k++) push_cycle(1'b0, (k < len), exp_at(k, len));
  endtask

  task automatic drive(input logic [1:0] s);
    @(negedge clk);
    rst  = s[1];
    in_k = s[0];
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [4:0] e, got;
    for (int k = 0; k < 3; k++) push_cycle(1'b1, 1'b1, 5'b0);
    push_press(2, 2);
    for (int c = 0; stim_q.size() > 0; c++) begin
      drive(stim_q.pop_front());
      e = exp_q.pop_front();
      got = {press, rel, lng, rpt, held};
      n_cmp++;
      if (got !== e) begin
        n_bad++;
        $display("FAIL reset cyc %0d: got p/r/l/rp/h=%b expected %b", c, got, e);
      end
    end
  endtask

  task automatic test_short_press();
    logic [4:0] e, got;
    push_press(3, 3);
    for (int c = 0; stim_q.size() > 0; c++) begin
      drive(stim_q.pop_front());
      e = exp_q.pop_front();
      got = {press, rel, lng, rpt, held};
      n_cmp++;
      if (got !== e) begin
        n_bad++;
        $display("FAIL short_press cyc %0d: got p/r/l/rp/h=%b expected %b", c, got, e);
      end
    end
  endtask

  task automatic test_long_repeat();
    logic [4:0] e, got;
    push_press(20, 2);
    for (int c = 0; stim_q.size() > 0; c++) begin
      drive(stim_q.pop_front());
      e = exp_q.pop_front();
      got = {press, rel, lng, rpt, held};
      n_cmp++;
      if (got !== e) begin
        n_bad++;
        $display("FAIL long_repeat cyc %0d: got p/r/l/rp/h=%b expected %b", c, got, e);
      end
    end
  endtask

  task automatic test_release_at_terminal();
    logic [4:0] e, got;
    push_press(8, 2);
    push_press(9, 2);
    for (int c = 0; stim_q.size() > 0; c++) begin
      drive(stim_q.pop_front());
      e = exp_q.pop_front();
      got = {press, rel, lng, rpt, held};
      n_cmp++;
      if (got !== e) begin
        n_bad++;
        $display("FAIL release_at_terminal cyc %0d: got p/r/l/rp/h=%b expected %b", c, got, e);
      end
    end
  endtask

  task automatic test_reset_mid_press();
    logic [4:0] e, got;
    for (int k = 0; k < 5; k++) push_cycle(1'b0, 1'b1, exp_at(k, 1000));
    push_cycle(1'b1, 1'b1, 5'b0);
    push_press(14, 2);
    for (int c = 0; stim_q.size() > 0; c++) begin
      drive(stim_q.pop_front());
      e = exp_q.pop_front();
      got = {press, rel, lng, rpt, held};
      n_cmp++;
      if (got !== e) begin
        n_bad++;
        $display("FAIL reset_mid_press cyc %0d: got p/r/l/rp/h=%b expected %b", c, got, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0] e, got;
    push_press(1, 1);
    push_press(2, 1);
    push_press(1, 3);
    for (int c = 0; stim_q.size() > 0; c++) begin
      drive(stim_q.pop_front());
      e = exp_q.pop_front();
      got = {press, rel, lng, rpt, held};
      n_cmp++;
      if (got !== e) begin
        n_bad++;
        $display("FAIL back_to_back cyc %0d: got p/r/l/rp/h=%b expected %b", c, got, e);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_short_press();
    test_long_repeat();
    test_release_at_terminal();
    test_reset_mid_press();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
